// File: rtl/udma_eth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udma_eth_pkg
// Description : Shared definitions for the uDMA Ethernet RX/TX controllers:
//               controller state encoding, uDMA data-size code and the bit
//               positions inside the per-frame status field.
// Revision    : 1.0 - initial release
// ============================================================================
package udma_eth_pkg;

  // Controller state encoding, shared by the RX and TX controllers
  typedef logic [1:0] eth_state_t;

  localparam eth_state_t ST_IDLE = 2'd0;
  localparam eth_state_t ST_ARM  = 2'd1;
  localparam eth_state_t ST_RECV = 2'd2;
  localparam eth_state_t ST_DROP = 2'd3;

  // uDMA transfer data size code: one byte per beat
  localparam logic [1:0] DATASIZE_BYTE = 2'b00;

  // Bit positions inside the frame status field {overflow, mac_error}
  localparam int STATUS_ERR_BIT = 0;
  localparam int STATUS_OVF_BIT = 1;

endpackage : udma_eth_pkg
`default_nettype wire

// File: rtl/udma_eth_rx_controller.sv
`default_nettype none
// ============================================================================
// Module      : udma_eth_rx_controller
// Description : Receive-side uDMA Ethernet controller. Takes a byte-wide
//               AXI-Stream of frames from the MAC and forwards each byte to
//               the uDMA RX channel. Frames longer than the programmed buffer
//               are truncated at capacity and the remainder is drained.
//               Reports length and {overflow, mac_error} of the last frame.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_eth_rx_controller
  import udma_eth_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,

  // uDMA RX channel configuration
  output logic [L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
  output logic [TRANS_SIZE-1:0]     cfg_rx_size_o,
  output logic [1:0]                cfg_rx_datasize_o,
  output logic                      cfg_rx_continuous_o,
  output logic                      cfg_rx_en_o,
  output logic                      cfg_rx_clr_o,
  input  logic                      cfg_rx_en_i,
  input  logic                      cfg_rx_pending_i,
  input  logic [L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
  input  logic [TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,

  // Register interface
  input  logic [L2_AWIDTH_NOAL-1:0] reg_rx_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     reg_rx_size_i,
  input  logic                      reg_rx_continuous_i,
  input  logic                      reg_rx_en_i,
  input  logic                      reg_rx_clr_i,
  output logic                      reg_rx_en_o,
  output logic                      reg_rx_pending_o,
  output logic [L2_AWIDTH_NOAL-1:0] reg_rx_curr_addr_o,
  output logic [TRANS_SIZE-1:0]     reg_rx_bytes_left_o,
  output logic [TRANS_SIZE-1:0]     reg_rx_frame_len_o,
  output logic [1:0]                reg_rx_status_o,
  output logic                      frame_done_o,
  output logic                      busy_o,

  // uDMA RX data channel
  output logic [31:0]               data_rx_o,
  output logic [1:0]                data_rx_datasize_o,
  output logic                      data_rx_valid_o,
  input  logic                      data_rx_ready_i,

  // AXI-Stream from the MAC
  input  logic [7:0]                s_axis_tdata_i,
  input  logic                      s_axis_tvalid_i,
  input  logic                      s_axis_tlast_i,
  input  logic                      s_axis_tuser_i,
  output logic                      s_axis_tready_o
);

  localparam logic [TRANS_SIZE-1:0] c_one = {{(TRANS_SIZE-1){1'b0}}, 1'b1};

  eth_state_t              r_state;
  logic [TRANS_SIZE-1:0]   r_byte_cnt;
  logic [TRANS_SIZE-1:0]   w_cnt_inc;
  logic                    w_room;
  logic                    w_beat;

  // Static configuration and status pass-through
  assign cfg_rx_datasize_o   = DATASIZE_BYTE;
  assign cfg_rx_continuous_o = reg_rx_continuous_i;
  assign cfg_rx_clr_o        = reg_rx_clr_i;
  assign reg_rx_en_o         = cfg_rx_en_i;
  assign reg_rx_pending_o    = cfg_rx_pending_i;
  assign reg_rx_curr_addr_o  = cfg_rx_curr_addr_i;
  assign reg_rx_bytes_left_o = cfg_rx_bytes_left_i;
  assign data_rx_datasize_o  = DATASIZE_BYTE;
  assign data_rx_o           = {24'h0, s_axis_tdata_i};
  assign busy_o              = (r_state != ST_IDLE);

  assign w_room    = (r_byte_cnt < cfg_rx_size_o);
  assign w_cnt_inc = r_byte_cnt + c_one;
  assign w_beat    = s_axis_tvalid_i & s_axis_tready_o;

  // Zero-latency handshake: MAC beats pass straight to uDMA while in RECV,
  // are swallowed in DROP and are held off everywhere else.
  always_comb begin
    data_rx_valid_o = 1'b0;
    s_axis_tready_o = 1'b0;
    case (r_state)
      ST_RECV: begin
        data_rx_valid_o = s_axis_tvalid_i & w_room;
        s_axis_tready_o = data_rx_ready_i & w_room;
      end
      ST_DROP: begin
        s_axis_tready_o = 1'b1;
      end
      default: begin
        data_rx_valid_o = 1'b0;
        s_axis_tready_o = 1'b0;
      end
    endcase
  end

  // Frame sequencing: arm the channel, count bytes, close the frame and
  // publish its length/status. Clear overrides everything, including arming.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state            <= ST_IDLE;
      r_byte_cnt         <= '0;
      cfg_rx_startaddr_o <= '0;
      cfg_rx_size_o      <= '0;
      cfg_rx_en_o        <= 1'b0;
      reg_rx_frame_len_o <= '0;
      reg_rx_status_o    <= 2'b00;
      frame_done_o       <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (reg_rx_clr_i) begin
        r_state     <= ST_IDLE;
        cfg_rx_en_o <= 1'b0;
        r_byte_cnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (reg_rx_en_i) begin
              cfg_rx_startaddr_o <= reg_rx_startaddr_i;
              cfg_rx_size_o      <= reg_rx_size_i;
              cfg_rx_en_o        <= 1'b1;
              r_byte_cnt         <= '0;
              reg_rx_status_o    <= 2'b00;
              r_state            <= ST_ARM;
            end
          end
          ST_ARM: begin
            if (cfg_rx_en_i && !cfg_rx_pending_i) begin
              cfg_rx_en_o <= 1'b0;
              // A zero-sized buffer cannot take any byte: drain the frame
              r_state     <= (cfg_rx_size_o == '0) ? ST_DROP : ST_RECV;
            end
          end
          ST_RECV: begin
            if (w_beat) begin
              r_byte_cnt <= w_cnt_inc;
              if (s_axis_tlast_i) begin
                reg_rx_frame_len_o                 <= w_cnt_inc;
                reg_rx_status_o[STATUS_OVF_BIT]    <= 1'b0;
                reg_rx_status_o[STATUS_ERR_BIT]    <= s_axis_tuser_i;
                frame_done_o                       <= 1'b1;
                r_state                            <= ST_IDLE;
              end else if (w_cnt_inc == cfg_rx_size_o) begin
                // Buffer full but frame continues: truncate and drain
                r_state <= ST_DROP;
              end
            end
          end
          ST_DROP: begin
            if (w_beat && s_axis_tlast_i) begin
              reg_rx_frame_len_o              <= r_byte_cnt;
              reg_rx_status_o[STATUS_OVF_BIT] <= 1'b1;
              reg_rx_status_o[STATUS_ERR_BIT] <= s_axis_tuser_i;
              frame_done_o                    <= 1'b1;
              r_state                         <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule : udma_eth_rx_controller
`default_nettype wire
